// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, issues req/ack fetches to instruction memory and
// registers the returned word with its PC and PC+4 for the decode stage.
module instruction_fetch #(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter logic [31:0]      NOP_INST     = 32'h0000_0013
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_fetch_en,
  input  logic            i_jump_req,
  input  logic [XLEN-1:0] i_jump_addr,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [31:0]     i_imem_rdata,
  output logic [31:0]     o_inst,
  output logic [XLEN-1:0] o_curr_pc_fd,
  output logic [XLEN-1:0] o_next_pc_fd,
  output logic            o_fetch_done,
  output logic            o_misaligned_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } fetch_state_t;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  fetch_state_t    r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [XLEN-1:0] r_imem_addr, w_imem_addr_nxt;
  logic [31:0]     r_inst, w_inst_nxt;
  logic [XLEN-1:0] r_curr_pc, w_curr_pc_nxt;
  logic [XLEN-1:0] r_next_pc, w_next_pc_nxt;
  logic            r_fetch_done, w_fetch_done_nxt;
  logic            r_misaligned, w_misaligned_nxt;
  logic            r_kill, w_kill_nxt;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_addr_plus4;

  assign w_target     = i_jump_req ? i_jump_addr : r_pc;
  assign w_addr_plus4 = r_imem_addr + PC_STEP;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_pc         <= RESET_VECTOR;
      r_imem_addr  <= RESET_VECTOR;
      r_inst       <= NOP_INST;
      r_curr_pc    <= RESET_VECTOR;
      r_next_pc    <= RESET_VECTOR + PC_STEP;
      r_fetch_done <= 1'b0;
      r_misaligned <= 1'b0;
      r_kill       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_imem_addr  <= w_imem_addr_nxt;
      r_inst       <= w_inst_nxt;
      r_curr_pc    <= w_curr_pc_nxt;
      r_next_pc    <= w_next_pc_nxt;
      r_fetch_done <= w_fetch_done_nxt;
      r_misaligned <= w_misaligned_nxt;
      r_kill       <= w_kill_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_imem_addr_nxt  = r_imem_addr;
    w_inst_nxt       = r_inst;
    w_curr_pc_nxt    = r_curr_pc;
    w_next_pc_nxt    = r_next_pc;
    w_fetch_done_nxt = 1'b0;
    w_misaligned_nxt = r_misaligned;
    w_kill_nxt       = r_kill;

    unique case (r_state)
      IDLE: begin
        if (i_fetch_en) begin
          w_pc_nxt = w_target;
          if (w_target[1:0] == 2'b00) begin
            w_imem_addr_nxt = w_target;
            w_state_nxt     = BUSY;
          end else begin
            w_misaligned_nxt = 1'b1;
          end
        end else if (i_jump_req) begin
          w_pc_nxt = i_jump_addr;
        end
      end

      BUSY: begin
        if (i_imem_ack) begin
          // A redirect seen during or at the end of the request makes the word stale.
          if (!r_kill && !i_jump_req) begin
            w_inst_nxt       = i_imem_rdata;
            w_curr_pc_nxt    = r_imem_addr;
            w_next_pc_nxt    = w_addr_plus4;
            w_pc_nxt         = w_addr_plus4;
            w_fetch_done_nxt = 1'b1;
          end else if (i_jump_req) begin
            w_pc_nxt = i_jump_addr;
          end
          w_kill_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else if (i_jump_req) begin
          w_kill_nxt = 1'b1;
          w_pc_nxt   = i_jump_addr;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_imem_req       = (r_state == BUSY);
  assign o_imem_addr      = r_imem_addr;
  assign o_inst           = r_inst;
  assign o_curr_pc_fd     = r_curr_pc;
  assign o_next_pc_fd     = r_next_pc;
  assign o_fetch_done     = r_fetch_done;
  assign o_misaligned_err = r_misaligned;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: hand-computed expectations for fetch,
// wait states, redirect kill, misaligned targets, PC wrap and mid-request reset.
module tb_instruction_fetch;

  logic        clk;
  logic        rstN;
  logic        fetchEn;
  logic        jumpReq;
  logic [31:0] jumpAddr;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic [31:0] inst;
  logic [31:0] currPc;
  logic [31:0] nextPc;
  logic        fetchDone;
  logic        misalignedErr;

  int vectorCount = 0;
  int missCount   = 0;

  instruction_fetch dut (
    .i_clk           (clk),
    .i_rst_n         (rstN),
    .i_fetch_en      (fetchEn),
    .i_jump_req      (jumpReq),
    .i_jump_addr     (jumpAddr),
    .o_imem_req      (imemReq),
    .o_imem_addr     (imemAddr),
    .i_imem_ack      (imemAck),
    .i_imem_rdata    (imemRdata),
    .o_inst          (inst),
    .o_curr_pc_fd    (currPc),
    .o_next_pc_fd    (nextPc),
    .o_fetch_done    (fetchDone),
    .o_misaligned_err(misalignedErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic fe, input logic jr, input logic [31:0] ja,
                               input logic ack, input logic [31:0] rdata);
    fetchEn   = fe;
    jumpReq   = jr;
    jumpAddr  = ja;
    imemAck   = ack;
    imemRdata = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstN = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("rst_req",  {31'd0, imemReq}, 32'd0);
    checkOutput("rst_addr", imemAddr, 32'h0);
    checkOutput("rst_inst", inst, 32'h0000_0013);
    checkOutput("rst_curr", currPc, 32'h0);
    checkOutput("rst_next", nextPc, 32'h4);
    checkOutput("rst_done", {31'd0, fetchDone}, 32'd0);
    checkOutput("rst_mis",  {31'd0, misalignedErr}, 32'd0);
    rstN = 1'b1;

    // Fetch from 0 with an immediate ack
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checkOutput("f1_req",  {31'd0, imemReq}, 32'd1);
    checkOutput("f1_addr", imemAddr, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h0050_0093);
    tick();
    checkOutput("f1_done", {31'd0, fetchDone}, 32'd1);
    checkOutput("f1_inst", inst, 32'h0050_0093);
    checkOutput("f1_curr", currPc, 32'h0);
    checkOutput("f1_next", nextPc, 32'h4);
    checkOutput("f1_req0", {31'd0, imemReq}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checkOutput("f1_pulse", {31'd0, fetchDone}, 32'd0);

    // Second fetch from 4, three wait cycles, fetch_en pulses ignored while busy
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checkOutput("f2_addr", imemAddr, 32'h4);
    for (int i = 0; i < 3; i++) begin
      applyStimulus((i % 2) == 0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      checkOutput("f2_wait_req",  {31'd0, imemReq}, 32'd1);
      checkOutput("f2_wait_addr", imemAddr, 32'h4);
      checkOutput("f2_wait_done", {31'd0, fetchDone}, 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h00A0_0113);
    tick();
    checkOutput("f2_done", {31'd0, fetchDone}, 32'd1);
    checkOutput("f2_inst", inst, 32'h00A0_0113);
    checkOutput("f2_curr", currPc, 32'h4);
    checkOutput("f2_next", nextPc, 32'h8);

    // Redirect during a busy fetch kills the returned word
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checkOutput("k_addr", imemAddr, 32'h8);
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    tick();
    checkOutput("k_req",  {31'd0, imemReq}, 32'd1);
    checkOutput("k_hold", imemAddr, 32'h8);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    tick();
    checkOutput("k_done", {31'd0, fetchDone}, 32'd0);
    checkOutput("k_inst", inst, 32'h00A0_0113);
    checkOutput("k_curr", currPc, 32'h4);
    checkOutput("k_req0", {31'd0, imemReq}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checkOutput("k_newaddr", imemAddr, 32'h100);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0513);
    tick();
    checkOutput("k_newcurr", currPc, 32'h100);
    checkOutput("k_newnext", nextPc, 32'h104);
    checkOutput("k_newinst", inst, 32'h0000_0513);

    // Fetch and jump together in IDLE fetch the jump target
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    tick();
    checkOutput("j_addr", imemAddr, 32'h200);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
    tick();
    checkOutput("j_curr", currPc, 32'h200);
    checkOutput("j_next", nextPc, 32'h204);
    checkOutput("j_inst", inst, 32'h1234_5678);

    // Misaligned target: no request, sticky error
    applyStimulus(1'b1, 1'b1, 32'h102, 1'b0, 32'h0);
    tick();
    checkOutput("m_req", {31'd0, imemReq}, 32'd0);
    checkOutput("m_err", {31'd0, misalignedErr}, 32'd1);
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
    tick();
    checkOutput("m_req2", {31'd0, imemReq}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0033);
    tick();
    checkOutput("m_curr",   currPc, 32'h300);
    checkOutput("m_sticky", {31'd0, misalignedErr}, 32'd1);

    // PC+4 wraps at the top of the address space
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0073);
    tick();
    checkOutput("w_curr", currPc, 32'hFFFF_FFFC);
    checkOutput("w_next", nextPc, 32'h0);
    checkOutput("w_done", {31'd0, fetchDone}, 32'd1);

    // Reset while busy, then a late ack must be ignored
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checkOutput("r_busy", {31'd0, imemReq}, 32'd1);
    checkOutput("r_addr", imemAddr, 32'h0);
    rstN = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checkOutput("r_req",  {31'd0, imemReq}, 32'd0);
    checkOutput("r_inst", inst, 32'h0000_0013);
    checkOutput("r_curr", currPc, 32'h0);
    checkOutput("r_next", nextPc, 32'h4);
    checkOutput("r_mis",  {31'd0, misalignedErr}, 32'd0);
    rstN = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0BAD);
    tick();
    checkOutput("r_lateack_done", {31'd0, fetchDone}, 32'd0);
    checkOutput("r_lateack_inst", inst, 32'h0000_0013);
    checkOutput("r_lateack_req",  {31'd0, imemReq}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage directly upstream of instruction_decode. It holds the program counter and issues one request per fetch_en to instruction memory over a req/ack handshake. It registers the returned word together with its PC and PC+4, producing inst, curr_pc_fd and next_pc_fd for decode. It accepts branch/jump redirects from downstream and discards any in-flight fetch that a redirect has made stale.

Parameters:
XLEN, 32, datapath / PC width
RESET_VECTOR, 0, PC value after reset; must be 4-byte aligned
NOP_INST, 32'h0000_0013, value of inst after reset (addi x0,x0,0)

Ports:
clk  in  1  CPU clock
rst_n  in  1  reset
fetch_en  in  1  stage-controller strobe: fetch the next instruction
jump_req  in  1  redirect request (taken branch / JAL / JALR)
jump_addr  in  XLEN  redirect target
imem_req  out  1  instruction memory request
imem_addr  out  XLEN  request address, stable while imem_req=1
imem_ack  in  1  imem_rdata valid this cycle; completes the request
imem_rdata  in  32  fetched word
inst  out  32  fetched instruction, to instruction_decode
curr_pc_fd  out  XLEN  PC of inst
next_pc_fd  out  XLEN  curr_pc_fd+4
fetch_done  out  1  one-cycle pulse: inst/curr_pc_fd/next_pc_fd updated this cycle
misaligned_err  out  1  sticky: a fetch target had [1:0]!=0

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous and active-low.
- Reset values:
  - pc=RESET_VECTOR; state=IDLE; imem_req=0; imem_addr=RESET_VECTOR.
  - inst=NOP_INST; curr_pc_fd=RESET_VECTOR; next_pc_fd=RESET_VECTOR+4.
  - fetch_done=0; misaligned_err=0; kill=0.
- Reset mid-request: the FSM goes to IDLE at the next edge; an ack arriving after reset is ignored.
- All outputs are registered. Arithmetic is modulo 2^XLEN, so PC+4 wraps silently.
- target = jump_req ? jump_addr : pc.
- IDLE (imem_req=0):
  - fetch_en=0, jump_req=1 -> pc<=jump_addr; stay IDLE.
  - fetch_en=1, target[1:0]==0 -> imem_addr<=target, pc<=target, go BUSY. imem_req is 1 from the next cycle.
  - fetch_en=1, target misaligned -> misaligned_err<=1, pc<=target, no request, stay IDLE.
  - imem_ack is ignored in IDLE.
- BUSY (imem_req=1, imem_addr held constant):
  - fetch_en is ignored.
  - jump_req=1 without imem_ack -> kill<=1, pc<=jump_addr. A later jump_req overwrites pc again (last one wins).
  - imem_ack=1, kill=0, jump_req=0:
    - inst<=imem_rdata, curr_pc_fd<=imem_addr, next_pc_fd<=imem_addr+4.
    - pc<=imem_addr+4, fetch_done<=1, go IDLE.
  - imem_ack=1 with kill=1 or jump_req=1:
    - Data is discarded; outputs and fetch_done are unchanged.
    - pc<=jump_addr if jump_req=1, else pc is kept.
    - kill<=0, go IDLE.
- fetch_done is high for exactly one cycle per accepted fetch and is never asserted for a killed fetch.
- Latency: fetch_en at edge N with same-cycle ack -> imem_req high in cycle N+1 -> outputs and fetch_done valid at N+2. With W wait cycles, outputs are valid at N+2+W.
- Maximum throughput is one instruction per two cycles; fetch_en may be asserted in the fetch_done cycle.
- misaligned_err clears only on reset.

Test Plan:
- Reset, then fetch_en with immediate ack, rdata=32'h00500093 -> inst=00500093, curr_pc_fd=0, next_pc_fd=4, fetch_done pulses once; second fetch reads addr 4.
- Ack delayed 3 cycles -> imem_req high 4 cycles with imem_addr constant; fetch_done only after ack; fetch_en pulses during BUSY are ignored.
- jump_req, jump_addr=0x100, during BUSY, then ack with rdata=0xDEADBEEF -> outputs unchanged, no fetch_done; next fetch has imem_addr=0x100.
- fetch_en and jump_req (0x200) together in IDLE -> imem_addr=0x200; result curr_pc_fd=0x200, next_pc_fd=0x204.
- jump_addr=0x102 with fetch_en -> no imem_req, misaligned_err=1 and stays 1 after further fetches, cleared only by rst_n=0.
- PC=0xFFFFFFFC fetch -> next_pc_fd=0; rst_n low while BUSY -> imem_req=0 next cycle, outputs at reset values, late ack ignored.
